// File: rtl/ram_fir_delay_ctrl_if.sv
// Sample handshake, tap-RAM ports and tap stream of the FIR delay-line controller.
// The controller uses the slave modport; the sample source / RAM / MAC side uses master.
interface ram_fir_delay_ctrl_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 9,
  parameter int TAPS   = 16
);
  localparam int TIDX_W = $clog2(TAPS);

  logic [DWIDTH-1:0] sample_i;
  logic              sample_valid_i;
  logic              ready_o;
  logic [DWIDTH-1:0] ram_wrdata_o;
  logic [AWIDTH-1:0] ram_wraddr_o;
  logic              ram_wren_o;
  logic [AWIDTH-1:0] ram_rdaddr_o;
  logic [DWIDTH-1:0] ram_rddata_i;
  logic [DWIDTH-1:0] tap_data_o;
  logic [TIDX_W-1:0] tap_idx_o;
  logic              tap_valid_o;
  logic              tap_last_o;

  modport slave (
    input  sample_i, sample_valid_i, ram_rddata_i,
    output ready_o, ram_wrdata_o, ram_wraddr_o, ram_wren_o, ram_rdaddr_o,
    output tap_data_o, tap_idx_o, tap_valid_o, tap_last_o
  );

  modport master (
    output sample_i, sample_valid_i, ram_rddata_i,
    input  ready_o, ram_wrdata_o, ram_wraddr_o, ram_wren_o, ram_rdaddr_o,
    input  tap_data_o, tap_idx_o, tap_valid_o, tap_last_o
  );
endinterface

// File: rtl/ram_fir_delay_ctrl.sv
// Circular delay-line controller: writes each accepted sample at the head pointer, then
// sweeps the newest TAPS RAM words newest-first and streams them out with index/last flags.
module ram_fir_delay_ctrl #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 9,
  parameter int TAPS   = 16
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  ram_fir_delay_ctrl_if.slave  bus_io
);
  localparam int TIDX_W = $clog2(TAPS);
  localparam logic [TIDX_W-1:0] LAST_IDX = TIDX_W'(TAPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e              state_q;
  logic                ready_q;
  logic                wren_q;
  logic [AWIDTH-1:0]   wraddr_q;
  logic [DWIDTH-1:0]   wrdata_q;
  logic [AWIDTH-1:0]   rdaddr_q;
  logic [AWIDTH-1:0]   wr_ptr_q;

  logic                iss_vld_q;
  logic [TIDX_W-1:0]   iss_idx_q;
  logic                iss_last_q;

  logic                rd_vld_q;
  logic [TIDX_W-1:0]   rd_idx_q;
  logic                rd_last_q;

  logic                tap_valid_q;
  logic [TIDX_W-1:0]   tap_idx_q;
  logic                tap_last_q;
  logic [DWIDTH-1:0]   tap_data_q;

  logic                accept_s;
  logic [TIDX_W-1:0]   idx_d;
  logic [AWIDTH-1:0]   rdaddr_d;

  assign accept_s = bus_io.sample_valid_i & ready_q;
  assign idx_d    = iss_idx_q + TIDX_W'(1);
  // Older taps sit below the head; natural modulo wrap walks across address 0.
  assign rdaddr_d = wr_ptr_q - AWIDTH'(idx_d);

  // Sequencer: one write slot, a TAPS-long read sweep, then a drain slot that may accept again.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      wren_q     <= 1'b0;
      wraddr_q   <= '0;
      wrdata_q   <= '0;
      rdaddr_q   <= '0;
      wr_ptr_q   <= '0;
      iss_vld_q  <= 1'b0;
      iss_idx_q  <= '0;
      iss_last_q <= 1'b0;
    end else begin
      wren_q     <= 1'b0;
      iss_vld_q  <= 1'b0;
      iss_last_q <= 1'b0;
      case (state_q)
        IDLE, DRAIN: begin
          if (accept_s) begin
            state_q  <= WRITE;
            ready_q  <= 1'b0;
            wren_q   <= 1'b1;
            wraddr_q <= wr_ptr_q;
            wrdata_q <= bus_io.sample_i;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        WRITE: begin
          state_q   <= READ;
          rdaddr_q  <= wr_ptr_q;
          iss_vld_q <= 1'b1;
          iss_idx_q <= '0;
        end
        READ: begin
          if (iss_idx_q == LAST_IDX) begin
            state_q  <= DRAIN;
            ready_q  <= 1'b1;
            wr_ptr_q <= wr_ptr_q + AWIDTH'(1);
          end else begin
            rdaddr_q   <= rdaddr_d;
            iss_vld_q  <= 1'b1;
            iss_idx_q  <= idx_d;
            iss_last_q <= (idx_d == LAST_IDX);
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Tap pipeline: flags track the RAM read latency, then one output stage carries data and flags together.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rd_vld_q    <= 1'b0;
      rd_idx_q    <= '0;
      rd_last_q   <= 1'b0;
      tap_valid_q <= 1'b0;
      tap_idx_q   <= '0;
      tap_last_q  <= 1'b0;
      tap_data_q  <= '0;
    end else begin
      rd_vld_q    <= iss_vld_q;
      rd_idx_q    <= iss_idx_q;
      rd_last_q   <= iss_last_q;
      tap_valid_q <= rd_vld_q;
      tap_idx_q   <= rd_idx_q;
      tap_last_q  <= rd_last_q;
      if (rd_vld_q) begin
        tap_data_q <= bus_io.ram_rddata_i;
      end else begin
        tap_data_q <= tap_data_q;
      end
    end
  end

  assign bus_io.ready_o      = ready_q;
  assign bus_io.ram_wren_o   = wren_q;
  assign bus_io.ram_wraddr_o = wraddr_q;
  assign bus_io.ram_wrdata_o = wrdata_q;
  assign bus_io.ram_rdaddr_o = rdaddr_q;
  assign bus_io.tap_valid_o  = tap_valid_q;
  assign bus_io.tap_idx_o    = tap_idx_q;
  assign bus_io.tap_last_o   = tap_last_q;
  assign bus_io.tap_data_o   = tap_data_q;
endmodule

// File: tb/tb_ram_fir_delay_ctrl.sv
// Bench for ram_fir_delay_ctrl: a small (8/4/4) and a default (16/9/16) instance, each with a
// RAM model, checked every cycle against a per-cycle schedule built from the accept history.
module tb_ram_fir_delay_ctrl;
  localparam int NCYC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst_s, srst_b, init_ram;

  ram_fir_delay_ctrl_if #(.DWIDTH(8),  .AWIDTH(4), .TAPS(4))  bus_s ();
  ram_fir_delay_ctrl_if #(.DWIDTH(16), .AWIDTH(9), .TAPS(16)) bus_b ();

  ram_fir_delay_ctrl #(.DWIDTH(8),  .AWIDTH(4), .TAPS(4))  dut_s (.clk_i(clk), .srst_i(srst_s), .bus_io(bus_s));
  ram_fir_delay_ctrl #(.DWIDTH(16), .AWIDTH(9), .TAPS(16)) dut_b (.clk_i(clk), .srst_i(srst_b), .bus_io(bus_b));

  // RAM models: synchronous write, one-clock read latency, preset contents before the run
  logic [7:0]  ram_s [16];
  logic [15:0] ram_b [512];
  always @(posedge clk) begin
    if (init_ram) begin
      for (int a = 0; a < 16; a++)  ram_s[a] <= 8'(8'hA0 + a);
      for (int a = 0; a < 512; a++) ram_b[a] <= 16'(16'hB000 + a);
    end else begin
      if (bus_s.ram_wren_o) ram_s[bus_s.ram_wraddr_o] <= bus_s.ram_wrdata_o;
      if (bus_b.ram_wren_o) ram_b[bus_b.ram_wraddr_o] <= bus_b.ram_wrdata_o;
    end
    bus_s.ram_rddata_i <= ram_s[bus_s.ram_rdaddr_o];
    bus_b.ram_rddata_i <= ram_b[bus_b.ram_rdaddr_o];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // model state (index 0 = small instance, 1 = default instance)
  int depth_a [2] = '{16, 512};
  int ntap_a  [2] = '{4, 16};
  int nxt_rdy [2];
  int wptr    [2];
  int acc_cnt [2];
  bit rst_seen [2];
  bit [15:0] mref [2][512];
  bit        e_wr  [2][NCYC];
  bit [15:0] e_wra [2][NCYC];
  bit [15:0] e_wrd [2][NCYC];
  bit        e_rd  [2][NCYC];
  bit [15:0] e_rda [2][NCYC];
  bit        e_tv  [2][NCYC];
  bit [15:0] e_td  [2][NCYC];
  int        e_ti  [2][NCYC];
  bit        e_tl  [2][NCYC];

  // observations of the DUT used by the directed literal checks
  logic [15:0] s_taps [$];
  logic [15:0] s_wra  [$];
  int          s_acc  [$];
  int          s_last_n = 0;
  logic [15:0] b_taps [$];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s got=%0h expected=%0h cycle=%0d", nm, got, exp, cyc);
    end
  endtask

  task automatic model_step(input int i, input logic rst, input logic vld, input logic [15:0] d);
    int a;
    int ra;
    int t;
    rst_seen[i] = rst;
    if (rst) begin
      wptr[i] = 0;
      nxt_rdy[i] = cyc + 1;
      for (int c = cyc + 1; c < NCYC; c++) begin
        e_wr[i][c] = 1'b0; e_rd[i][c] = 1'b0; e_tv[i][c] = 1'b0; e_tl[i][c] = 1'b0;
      end
    end else if (vld === 1'b1 && cyc >= nxt_rdy[i] && cyc + ntap_a[i] + 6 < NCYC) begin
      a = wptr[i];
      mref[i][a] = d;
      e_wr[i][cyc+1] = 1'b1; e_wra[i][cyc+1] = 16'(a); e_wrd[i][cyc+1] = d;
      for (int k = 0; k < ntap_a[i]; k++) begin
        ra = (a - k + depth_a[i]) % depth_a[i];
        t = cyc + 4 + k;
        e_rd[i][cyc+2+k] = 1'b1; e_rda[i][cyc+2+k] = 16'(ra);
        e_tv[i][t] = 1'b1; e_td[i][t] = mref[i][ra]; e_ti[i][t] = k;
        e_tl[i][t] = (k == ntap_a[i] - 1);
      end
      nxt_rdy[i] = cyc + ntap_a[i] + 2;
      wptr[i] = (a + 1) % depth_a[i];
      acc_cnt[i]++;
    end
  endtask

  // Model update at each active edge from the inputs that edge samples
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int a = 0; a < 16; a++)  mref[0][a] = 16'(8'hA0 + a);
      for (int a = 0; a < 512; a++) mref[1][a] = 16'(16'hB000 + a);
    end
    if (srst_s === 1'b0 && bus_s.sample_valid_i === 1'b1 && bus_s.ready_o === 1'b1) s_acc.push_back(cyc);
    model_step(0, srst_s, bus_s.sample_valid_i, 16'(bus_s.sample_i));
    model_step(1, srst_b, bus_b.sample_valid_i, bus_b.sample_i);
    cyc++;
  end

  task automatic cmp_inst(input int i, input logic rdy, input logic wren, input logic [15:0] wra,
                          input logic [15:0] wrd, input logic [15:0] rda, input logic tv,
                          input logic [15:0] td, input logic [15:0] ti, input logic tl);
    check($sformatf("ready%0d", i), 32'(rdy), 32'(cyc >= nxt_rdy[i]));
    check($sformatf("wren%0d", i), 32'(wren), 32'(e_wr[i][cyc]));
    if (e_wr[i][cyc]) begin
      check($sformatf("wraddr%0d", i), 32'(wra), 32'(e_wra[i][cyc]));
      check($sformatf("wrdata%0d", i), 32'(wrd), 32'(e_wrd[i][cyc]));
    end
    if (e_rd[i][cyc]) check($sformatf("rdaddr%0d", i), 32'(rda), 32'(e_rda[i][cyc]));
    check($sformatf("tap_valid%0d", i), 32'(tv), 32'(e_tv[i][cyc]));
    check($sformatf("tap_last%0d", i), 32'(tl), 32'(e_tl[i][cyc]));
    if (e_tv[i][cyc]) begin
      check($sformatf("tap_data%0d", i), 32'(td), 32'(e_td[i][cyc]));
      check($sformatf("tap_idx%0d", i), 32'(ti), 32'(e_ti[i][cyc]));
    end
    if (rst_seen[i]) begin
      check($sformatf("rst_wraddr%0d", i), 32'(wra), 32'd0);
      check($sformatf("rst_wrdata%0d", i), 32'(wrd), 32'd0);
      check($sformatf("rst_rdaddr%0d", i), 32'(rda), 32'd0);
      check($sformatf("rst_tapdata%0d", i), 32'(td), 32'd0);
      check($sformatf("rst_tapidx%0d", i), 32'(ti), 32'd0);
    end
  endtask

  // Per-cycle comparison against the model, plus recording of the observed streams
  always @(negedge clk) begin
    if (cyc >= 1) begin
      cmp_inst(0, bus_s.ready_o, bus_s.ram_wren_o, 16'(bus_s.ram_wraddr_o), 16'(bus_s.ram_wrdata_o),
               16'(bus_s.ram_rdaddr_o), bus_s.tap_valid_o, 16'(bus_s.tap_data_o),
               16'(bus_s.tap_idx_o), bus_s.tap_last_o);
      cmp_inst(1, bus_b.ready_o, bus_b.ram_wren_o, 16'(bus_b.ram_wraddr_o), bus_b.ram_wrdata_o,
               16'(bus_b.ram_rdaddr_o), bus_b.tap_valid_o, bus_b.tap_data_o,
               16'(bus_b.tap_idx_o), bus_b.tap_last_o);
      if (bus_s.tap_valid_o === 1'b1) s_taps.push_back(16'(bus_s.tap_data_o));
      if (bus_s.ram_wren_o === 1'b1)  s_wra.push_back(16'(bus_s.ram_wraddr_o));
      if (bus_s.tap_last_o === 1'b1)  s_last_n++;
      if (bus_b.tap_valid_o === 1'b1) b_taps.push_back(bus_b.tap_data_o);
    end
  end

  // Offer one sample and hold it until the model sees it accepted (called on a negedge)
  task automatic send(input int i, input logic [15:0] d);
    int start;
    int n;
    start = acc_cnt[i];
    n = 0;
    if (i == 0) begin bus_s.sample_i = d[7:0]; bus_s.sample_valid_i = 1'b1; end
    else begin bus_b.sample_i = d; bus_b.sample_valid_i = 1'b1; end
    while (acc_cnt[i] == start && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (i == 0) bus_s.sample_valid_i = 1'b0;
    else bus_b.sample_valid_i = 1'b0;
    check($sformatf("accept_seen%0d", i), 32'(acc_cnt[i] != start), 32'd1);
  endtask

  initial begin
    #(NCYC * 10);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int base;
    int wb;
    int ab;
    int lastsnap;
    logic [15:0] b_first;
    logic [15:0] d;
    init_ram = 1'b1;
    srst_s = 1'b1; srst_b = 1'b1;
    bus_s.sample_i = '0; bus_s.sample_valid_i = 1'b0;
    bus_b.sample_i = '0; bus_b.sample_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    init_ram = 1'b0;
    srst_s = 1'b0; srst_b = 1'b0;
    @(negedge clk);

    // tests 1/2: first sample, then back-to-back accept in the drain slot
    send(0, 16'h11);
    send(0, 16'h22);
    repeat (10) @(negedge clk);
    check("t1_wraddr", 32'(s_wra[0]), 32'd0);
    check("t1_tap0", 32'(s_taps[0]), 32'h11);
    check("t1_tap1", 32'(s_taps[1]), 32'hAF);
    check("t1_tap2", 32'(s_taps[2]), 32'hAE);
    check("t1_tap3", 32'(s_taps[3]), 32'hAD);
    check("t2_wraddr", 32'(s_wra[1]), 32'd1);
    check("t2_tap0", 32'(s_taps[4]), 32'h22);
    check("t2_tap1", 32'(s_taps[5]), 32'h11);
    check("t2_tap2", 32'(s_taps[6]), 32'hAF);
    check("t2_tap3", 32'(s_taps[7]), 32'hAE);
    check("t2_spacing", 32'(s_acc[1] - s_acc[0]), 32'd6);
    check("t2_last_count", 32'(s_last_n), 32'd2);

    // test 3: 17 samples from pointer 0 wrap the 16-deep ring
    srst_s = 1'b1;
    @(negedge clk);
    srst_s = 1'b0;
    base = s_taps.size();
    wb = s_wra.size();
    for (int j = 1; j <= 17; j++) send(0, 16'(j));
    repeat (10) @(negedge clk);
    check("t3_ntaps", 32'(s_taps.size() - base), 32'd68);
    check("t3_wraddr16", 32'(s_wra[wb+15]), 32'd15);
    check("t3_wraddr17", 32'(s_wra[wb+16]), 32'd0);
    check("t3_tap0", 32'(s_taps[base+64]), 32'h11);
    check("t3_tap1", 32'(s_taps[base+65]), 32'h10);
    check("t3_tap2", 32'(s_taps[base+66]), 32'h0F);
    check("t3_tap3", 32'(s_taps[base+67]), 32'h0E);

    // test 4: sample_valid_i held high for 30 cycles
    ab = s_acc.size();
    wb = s_wra.size();
    bus_s.sample_valid_i = 1'b1;
    for (int j = 0; j < 30; j++) begin
      bus_s.sample_i = 8'(8'h40 + j);
      @(negedge clk);
    end
    bus_s.sample_valid_i = 1'b0;
    repeat (12) @(negedge clk);
    check("t4_accepts", 32'(s_acc.size() - ab), 32'd5);
    for (int j = ab + 1; j < s_acc.size(); j++)
      check("t4_spacing", 32'(s_acc[j] - s_acc[j-1]), 32'd6);
    check("t4_wren_pulses", 32'(s_wra.size() - wb), 32'(s_acc.size() - ab));

    // test 5: reset while the sweep shows tap index 2
    base = s_taps.size();
    lastsnap = s_last_n;
    send(0, 16'h55);
    repeat (3) @(negedge clk);
    srst_s = 1'b1;
    @(negedge clk);
    srst_s = 1'b0;
    check("t5_ready", 32'(bus_s.ready_o), 32'd1);
    check("t5_tap_valid", 32'(bus_s.tap_valid_o), 32'd0);
    repeat (8) @(negedge clk);
    check("t5_no_last", 32'(s_last_n - lastsnap), 32'd0);
    check("t5_truncated", 32'(s_taps.size() - base), 32'd1);
    send(0, 16'h66);
    repeat (8) @(negedge clk);
    check("t5_wraddr_after", 32'(s_wra[s_wra.size()-1]), 32'd0);
    check("t5_tap0_after", 32'(s_taps[s_taps.size()-4]), 32'h66);

    // test 6: default parameters, random samples with occasional gaps
    b_first = '0;
    for (int j = 0; j < 30; j++) begin
      d = 16'($urandom);
      if (j == 0) b_first = d;
      send(1, d);
      if (j % 5 == 3) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (24) @(negedge clk);
    check("t6_ntaps", 32'(b_taps.size()), 32'd480);
    check("t6_tap0", 32'(b_taps[0]), 32'(b_first));
    check("t6_tap1_prehist", 32'(b_taps[1]), 32'hB1FF);
    check("t6_tap15_prehist", 32'(b_taps[15]), 32'hB1F1);
    check("t6_second_tap1", 32'(b_taps[17]), 32'(b_first));
    check("cycle_budget", 32'(cyc < NCYC - 64), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
